lamp_seq_checker: RTL

LAMP_SEQ_CHECKER -- requirements
Module: lamp_seq_checker

---
 rtl/lamp_seq_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lamp_seq_checker.sv
// lamp_seq_checker: watches a cyclic red->green->yellow lamp code stream,
// tracks the current phase and its dwell, counts completed cycles, and
// latches a sticky fault with its cause when the sequence misbehaves.
module lamp_seq_checker #(
    parameter int unsigned MIN_DWELL = 2,
    parameter int unsigned MAX_DWELL = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] cycle_count,
    output logic       cycle_pulse,
    output logic [7:0] last_dwell
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [7:0] MIN_D = MIN_DWELL[7:0];
    localparam logic [7:0] MAX_D = MAX_DWELL[7:0];

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL = 2'd1;
    localparam logic [1:0] CODE_ORDER   = 2'd2;
    localparam logic [1:0] CODE_DWELL   = 2'd3;

    state_t     state_reg, state_next;
    logic [1:0] phase_reg, phase_next;
    logic       err_reg, err_next;
    logic [1:0] err_code_reg, err_code_next;
    logic [7:0] cycle_count_reg, cycle_count_next;
    logic       cycle_pulse_reg, cycle_pulse_next;
    logic [7:0] last_dwell_reg, last_dwell_next;
    logic [7:0] dwell_reg, dwell_next;

    logic [1:0] light_phase;   // 0 when the sampled code is illegal
    logic [1:0] succ_phase;    // phase legally following the tracked one
    logic [7:0] dwell_inc;     // saturating increment of the dwell counter

    // Decode the one-hot lamp code into a phase number.
    always_comb begin
        light_phase = 2'd0;
        case (light)
            3'b100:  light_phase = 2'd1;
            3'b001:  light_phase = 2'd2;
            3'b010:  light_phase = 2'd3;
            default: light_phase = 2'd0;
        endcase
    end

    assign succ_phase = (phase_reg == 2'd3) ? 2'd1 : phase_reg + 2'd1;
    assign dwell_inc  = (dwell_reg == 8'hFF) ? dwell_reg : dwell_reg + 8'd1;

    // Next-state and next-output evaluation for one light sample.
    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        err_next         = err_reg;
        err_code_next    = err_code_reg;
        cycle_count_next = cycle_count_reg;
        cycle_pulse_next = 1'b0;
        last_dwell_next  = last_dwell_reg;
        dwell_next       = dwell_reg;

        if (clr) begin
            // Resynchronise; history counters survive a clear.
            state_next    = IDLE;
            phase_next    = 2'd0;
            err_next      = 1'b0;
            err_code_next = CODE_NONE;
            dwell_next    = 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (light_phase != 2'd0) begin
                        state_next = TRACK;
                        phase_next = light_phase;
                        dwell_next = 8'd1;
                    end
                end
                TRACK: begin
                    if (light_phase == phase_reg) begin
                        dwell_next = dwell_inc;
                        if (dwell_inc > MAX_D) begin
                            state_next    = FAULT;
                            err_next      = 1'b1;
                            err_code_next = CODE_DWELL;
                        end
                    end else if (light_phase == 2'd0) begin
                        state_next    = FAULT;
                        err_next      = 1'b1;
                        err_code_next = CODE_ILLEGAL;
                    end else if (light_phase != succ_phase) begin
                        state_next    = FAULT;
                        err_next      = 1'b1;
                        err_code_next = CODE_ORDER;
                    end else if (dwell_reg < MIN_D) begin
                        state_next    = FAULT;
                        err_next      = 1'b1;
                        err_code_next = CODE_DWELL;
                    end else begin
                        last_dwell_next = dwell_reg;
                        dwell_next      = 8'd1;
                        phase_next      = light_phase;
                        // Yellow->red closes a full cycle.
                        if (phase_reg == 2'd3) begin
                            cycle_count_next = cycle_count_reg + 8'd1;
                            cycle_pulse_next = 1'b1;
                        end
                    end
                end
                FAULT: begin
                    // Everything holds until a clear.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            phase_reg       <= 2'd0;
            err_reg         <= 1'b0;
            err_code_reg    <= CODE_NONE;
            cycle_count_reg <= 8'd0;
            cycle_pulse_reg <= 1'b0;
            last_dwell_reg  <= 8'd0;
            dwell_reg       <= 8'd0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            err_reg         <= err_next;
            err_code_reg    <= err_code_next;
            cycle_count_reg <= cycle_count_next;
            cycle_pulse_reg <= cycle_pulse_next;
            last_dwell_reg  <= last_dwell_next;
            dwell_reg       <= dwell_next;
        end
    end

    assign phase       = phase_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;
    assign cycle_count = cycle_count_reg;
    assign cycle_pulse = cycle_pulse_reg;
    assign last_dwell  = last_dwell_reg;

endmodule
